uart_tx_buffered: RTL and testbench

Buffered 8N1 UART transmitter for the host link. It is the outbound counterpart of the receive path that feeds keyboard_driver. Game logic (score/status reporting) pushes bytes into an internal FIFO. The block serialises them LSB-first onto tx at the configured baud rate and runs in the 65 MHz pixel clock domain.

---
 rtl/uart_tx_buffered.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding an LSB-first serialiser.
// tx, busy, flags and count are all registered outputs.
module uart_tx_buffered #(
  parameter int CLK_FREQ   = 65000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  input  logic                          overflow_clr,
  output logic                          tx,
  output logic                          busy,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             ovf_q, ovf_d;
  logic             pop;
  logic             wr_acc;
  logic             bit_end;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is queued.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

  // FIFO bookkeeping; a dropped write flags overflow even when a pop frees a slot.
  always_comb begin
    wr_acc   = wr_en & ~full_q;
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_acc);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + (PTR_W+1)'(wr_acc) - (PTR_W+1)'(pop);
    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == '0);
    ovf_d    = (wr_en & full_q) | (ovf_q & ~overflow_clr);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    bit_end = (cnt_q == CNT_LAST);
    case (state_q)
      S_IDLE: begin
        if (!empty_q) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == STOP_LAST) state_d = S_IDLE;
          else                    bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from next state so tx/busy come straight from flops.
  always_comb begin
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE) | ~empty_d;
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_full  = full_q;
  assign fifo_empty = empty_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: timeline model + receiver for the small config,
// edge-timing measurement for a full-rate STOP_BITS=2 instance.
module tb_uart_tx_buffered;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int SB    = 1;
  localparam int F     = (9 + SB) * CPB;
  localparam int CPB2  = 6770;
  localparam int F2    = 11 * CPB2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, wr_en = 1'b0, overflow_clr = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       tx, busy, fifo_full, fifo_empty, overflow;
  logic [2:0] fifo_count;

  logic       wr_en2 = 1'b0, clr2 = 1'b0;
  logic [7:0] wr_data2 = 8'h00;
  logic       tx2, busy2, full2, empty2, ovf2;
  logic [4:0] count2;

  uart_tx_buffered #(.CLK_FREQ(160), .BAUD(10), .FIFO_DEPTH(DEPTH), .STOP_BITS(SB)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .overflow_clr(overflow_clr),
    .tx(tx), .busy(busy), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_count(fifo_count), .overflow(overflow));

  uart_tx_buffered #(.CLK_FREQ(65000000), .BAUD(9600), .FIFO_DEPTH(16), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en2), .wr_data(wr_data2), .overflow_clr(clr2),
    .tx(tx2), .busy(busy2), .fifo_full(full2), .fifo_empty(empty2),
    .fifo_count(count2), .overflow(ovf2));

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Timeline model: a byte leaves the queue at the first edge whose preceding
  // cycle is outside any frame; the frame then occupies F cycles from that edge.
  logic [7:0] mq[$];
  bit         m_act = 1'b0, m_ovf = 1'b0, m_prev, m_acc;
  int         m_fs = 0;
  logic [7:0] m_byte = 8'h00;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      mq.delete();
      m_act = 1'b0;
      m_ovf = 1'b0;
    end else begin
      m_prev = m_act && (cyc - 1 < m_fs + F);
      m_acc  = wr_en && (mq.size() < DEPTH);
      if (wr_en && !m_acc) m_ovf = 1'b1;
      else if (overflow_clr) m_ovf = 1'b0;
      if (!m_prev && mq.size() > 0) begin
        m_byte = mq.pop_front();
        m_act  = 1'b1;
        m_fs   = cyc;
      end
      if (m_acc) mq.push_back(wr_data);
    end
  end

  function automatic bit m_in_frame();
    return m_act && (cyc >= m_fs) && (cyc < m_fs + F);
  endfunction

  function automatic logic m_tx();
    int off;
    if (!m_in_frame()) return 1'b1;
    off = cyc - m_fs;
    if (off < CPB) return 1'b0;
    if (off < 9 * CPB) return m_byte[off / CPB - 1];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tx", tx, m_tx());
      chk("busy", busy, m_in_frame() || (mq.size() > 0));
      chk("fifo_count", fifo_count, mq.size());
      chk("fifo_full", fifo_full, mq.size() == DEPTH);
      chk("fifo_empty", fifo_empty, mq.size() == 0);
      chk("overflow", overflow, m_ovf);
    end
  end

  // Bench UART receiver sampling at mid-bit
  logic [7:0] rxq[$];
  int         rxt[$];
  logic       rx_prev = 1'b1;
  bit         rx_act = 1'b0;
  int         rx_fall = 0, rx_off, rx_k;
  logic [7:0] rx_sh = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (rx_prev && !tx) begin
        rx_act  = 1'b1;
        rx_fall = cyc;
      end
    end else begin
      rx_off = cyc - rx_fall;
      if (rx_off >= CPB + CPB / 2 && ((rx_off - CPB / 2) % CPB) == 0) begin
        rx_k = (rx_off - CPB / 2) / CPB;
        if (rx_k <= 8) rx_sh[rx_k-1] = tx;
        else begin
          chk("rx_stop", tx, 1);
          rxq.push_back(rx_sh);
          rxt.push_back(rx_fall);
          rx_act = 1'b0;
        end
      end
    end
    rx_prev = tx;
  end

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; wr_en = 1'b0; overflow_clr = 1'b0; wr_en2 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rxq.delete();
    rxt.delete();
  endtask

  int t0, lows, peak, tt, bfall;
  int exp1[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
  int tr[$];
  logic p_tx, p_busy;

  initial begin
    // Reset state
    do_reset();
    chk_en = 1'b1;
    chk("rst_tx", tx, 1);       chk("rst_busy", busy, 0);
    chk("rst_full", fifo_full, 0); chk("rst_empty", fifo_empty, 1);
    chk("rst_count", fifo_count, 0); chk("rst_ovf", overflow, 0);
    chk("rst2_tx", tx2, 1);     chk("rst2_busy", busy2, 0);
    chk("rst2_flags", {full2, empty2, ovf2}, 3'b010); chk("rst2_count", count2, 0);

    // 1: single byte 0xA5
    t0 = cyc;
    wr_en = 1'b1; wr_data = 8'hA5;
    wait_to(t0 + 1); wr_en = 1'b0;
    chk("t1_tx_c1", tx, 1); chk("t1_empty_c1", fifo_empty, 0);
    wait_to(t0 + 2);  chk("t1_start_fall", tx, 0);
    wait_to(t0 + 17); chk("t1_start_end", tx, 0);
    for (int k = 0; k < 8; k++) begin
      wait_to(t0 + 2 + CPB * (k + 1) + CPB / 2);
      chk("t1_bit", tx, exp1[k]);
    end
    wait_to(t0 + 146); chk("t1_stop", tx, 1);
    wait_to(t0 + 161); chk("t1_busy_161", busy, 1);
    wait_to(t0 + 162); chk("t1_busy_162", busy, 0);
    chk("t1_rx_n", rxq.size(), 1);
    if (rxq.size() == 1) chk("t1_rx_byte", rxq[0], 8'hA5);

    // 2: burst of three
    do_reset();
    t0 = cyc; peak = 0;
    for (int i = 0; i < 3; i++) begin
      wait_to(t0 + i); wr_en = 1'b1; wr_data = 8'(i + 1);
    end
    for (int c = t0 + 3; c < t0 + 2 + 3 * (F + 1) + 4; c++) begin
      wait_to(c);
      wr_en = 1'b0;
      if (int'(fifo_count) > peak) peak = fifo_count;
    end
    chk("t2_peak", peak, 2);
    chk("t2_rx_n", rxq.size(), 3);
    if (rxq.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("t2_rx_byte", rxq[i], i + 1);
      chk("t2_gap01", rxt[1] - rxt[0], 161);
      chk("t2_gap12", rxt[2] - rxt[1], 161);
      chk("t2_first", rxt[0] - t0, 2);
    end

    // 3: overflow on sixth write
    do_reset();
    t0 = cyc;
    for (int i = 0; i < 6; i++) begin
      wait_to(t0 + i); wr_en = 1'b1; wr_data = 8'(8'h11 + i);
    end
    wait_to(t0 + 6); wr_en = 1'b0;
    chk("t3_count", fifo_count, 4); chk("t3_full", fifo_full, 1); chk("t3_ovf", overflow, 1);
    wait_to(t0 + 812);
    chk("t3_rx_n", rxq.size(), 5);
    if (rxq.size() == 5)
      for (int i = 0; i < 5; i++) chk("t3_rx_byte", rxq[i], 8'h11 + i);
    chk("t3_ovf_sticky", overflow, 1);
    overflow_clr = 1'b1;
    wait_to(t0 + 813); overflow_clr = 1'b0;
    chk("t3_ovf_clr", overflow, 0);

    // 4: write into full FIFO on the pop cycle
    do_reset();
    t0 = cyc;
    for (int i = 0; i < 5; i++) begin
      wait_to(t0 + i); wr_en = 1'b1; wr_data = 8'(8'h21 + i);
    end
    wait_to(t0 + 5); wr_en = 1'b0;
    wait_to(t0 + 161); chk("t4_full", fifo_full, 1); chk("t4_count4", fifo_count, 4);
    wait_to(t0 + 162); wr_en = 1'b1; wr_data = 8'h99;
    wait_to(t0 + 163); wr_en = 1'b0;
    chk("t4_ovf", overflow, 1); chk("t4_count3", fifo_count, 3); chk("t4_tx_start", tx, 0);
    wait_to(t0 + 820);
    chk("t4_rx_n", rxq.size(), 5);
    if (rxq.size() == 5)
      for (int i = 0; i < 5; i++) chk("t4_rx_byte", rxq[i], 8'h21 + i);

    // 5: reset during data bit 3 with two queued
    do_reset();
    t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      wait_to(t0 + i); wr_en = 1'b1; wr_data = 8'(8'h31 + i);
    end
    wait_to(t0 + 3); wr_en = 1'b0;
    wait_to(t0 + 70); chk("t5_count", fifo_count, 2);
    rst = 1'b1;
    wait_to(t0 + 71); rst = 1'b0;
    chk("t5_tx", tx, 1); chk("t5_empty", fifo_empty, 1); chk("t5_busy", busy, 0);
    lows = 0;
    for (int c = t0 + 72; c < t0 + 272; c++) begin
      wait_to(c);
      if (tx == 1'b0) lows++;
    end
    chk("t5_quiet", lows, 0);

    // 6: full-rate, two stop bits, 0x55
    chk_en = 1'b0;
    t0 = cyc;
    wr_en2 = 1'b1; wr_data2 = 8'h55;
    wait_to(t0 + 1); wr_en2 = 1'b0;
    tt = t0 + 2; bfall = -1;
    p_tx = tx2; p_busy = busy2;
    for (int c = tt; c <= tt + F2 + 3; c++) begin
      wait_to(c);
      if (tx2 !== p_tx) tr.push_back(c - tt);
      if (p_busy && !busy2 && bfall < 0) bfall = c - tt;
      p_tx = tx2; p_busy = busy2;
    end
    chk("t6_edges", tr.size(), 10);
    if (tr.size() == 10)
      for (int k = 0; k < 10; k++) chk("t6_edge_at", tr[k], k * CPB2);
    chk("t6_busy_fall", bfall, 74470);
    if (tr.size() == 10) chk("t6_stop_len", bfall - tr[9], 13540);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
